riscv_run_monitor: RTL and testbench

Parametrised, synthesisable run controller and commit monitor for the single-cycle RISC-V CPU. Sits beside `SingleCycleCPU`, samples its per-cycle architectural signals, and decides when a program run has finished: halt on `ecall`/`ebreak` or a PC self-loop, or timeout after a cycle budget. It accumulates instruction, store and taken-branch counts plus a rotating XOR signature of all architectural writes. Benches and FPGA top levels use it to stop on a decision instead of a fixed wall-clock delay.

---
 rtl/riscv_run_monitor_if.sv | 31 +++
 rtl/riscv_run_monitor.sv | 92 +++++++++
 tb/tb_riscv_run_monitor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_run_monitor_if.sv
// riscv_run_monitor_if: sampled CPU signals in, run decision and statistics out
interface riscv_run_monitor_if #(parameter int XLEN = 32, parameter int CNT_W = 32);
  logic            en;
  logic            clr;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic            reg_write;
  logic [XLEN-1:0] wb_data;
  logic            mem_write;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            branch;
  logic            zero;
  logic [1:0]      state;
  logic            done;
  logic            timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] store_cnt;
  logic [CNT_W-1:0] br_taken_cnt;
  logic [XLEN-1:0] signature;
  logic [XLEN-1:0] halt_pc;
  modport master (
    output en, clr, pc, instr, reg_write, wb_data, mem_write, mem_addr, mem_wdata, branch, zero,
    input  state, done, timeout, cycle_cnt, instr_cnt, store_cnt, br_taken_cnt, signature, halt_pc
  );
  modport slave (
    input  en, clr, pc, instr, reg_write, wb_data, mem_write, mem_addr, mem_wdata, branch, zero,
    output state, done, timeout, cycle_cnt, instr_cnt, store_cnt, br_taken_cnt, signature, halt_pc
  );
endinterface

// File: rtl/riscv_run_monitor.sv
// riscv_run_monitor: decides halt/timeout for a CPU run and accumulates commit statistics
module riscv_run_monitor #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 300,
  parameter int HALT_REPEAT = 4
) (
  input logic clk,
  input logic start,
  riscv_run_monitor_if.slave mon
);
  localparam int RW = $clog2(HALT_REPEAT + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2, TIMEOUT = 2'd3} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d, st_q, st_d, br_q, br_d;
  logic [XLEN-1:0] sig_q, sig_d, hpc_q, hpc_d, prev_q, prev_d, s1, s2;
  logic [RW-1:0] rep_q, rep_d;
  logic valid_q, valid_d;
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v, input logic c);
    return (c && !(&v)) ? v + 1'b1 : v;
  endfunction
  function automatic logic [XLEN-1:0] rotl1(input logic [XLEN-1:0] v);
    return {v[XLEN-2:0], v[XLEN-1]};
  endfunction
  assign s1 = (mon.reg_write && mon.instr[11:7] != 5'd0) ? rotl1(sig_q) ^ mon.wb_data : sig_q;
  assign s2 = mon.mem_write ? rotl1(s1) ^ (mon.mem_addr ^ mon.mem_wdata) : s1;
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    st_d    = st_q;
    br_d    = br_q;
    sig_d   = sig_q;
    hpc_d   = hpc_q;
    prev_d  = prev_q;
    rep_d   = rep_q;
    valid_d = valid_q;
    if (state_q == IDLE) begin
      state_d = mon.en ? RUN : IDLE;
    end else if (state_q == RUN && mon.en) begin
      cyc_d   = inc(cyc_q, 1'b1);
      ins_d   = inc(ins_q, mon.instr != 32'd0);
      st_d    = inc(st_q, mon.mem_write);
      br_d    = inc(br_q, mon.branch & mon.zero);
      sig_d   = s2;
      rep_d   = (valid_q && mon.pc == prev_q) ? ((&rep_q) ? rep_q : rep_q + 1'b1) : '0;
      prev_d  = mon.pc;
      valid_d = 1'b1;
      // halt takes priority over a timeout landing on the same cycle
      if (mon.instr == 32'h00000073 || mon.instr == 32'h00100073 || rep_d == RW'(HALT_REPEAT)) begin
        state_d = HALTED;
        hpc_d   = mon.pc;
      end else if (cyc_d == CNT_W'(MAX_CYCLES)) begin
        state_d = TIMEOUT;
      end
    end
  end
  always_ff @(posedge clk or negedge start) begin
    if (!start || mon.clr) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      ins_q   <= '0;
      st_q    <= '0;
      br_q    <= '0;
      sig_q   <= '0;
      hpc_q   <= '0;
      prev_q  <= '0;
      rep_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      st_q    <= st_d;
      br_q    <= br_d;
      sig_q   <= sig_d;
      hpc_q   <= hpc_d;
      prev_q  <= prev_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
    end
  end
  assign mon.state        = state_q;
  assign mon.done         = state_q == HALTED || state_q == TIMEOUT;
  assign mon.timeout      = state_q == TIMEOUT;
  assign mon.cycle_cnt    = cyc_q;
  assign mon.instr_cnt    = ins_q;
  assign mon.store_cnt    = st_q;
  assign mon.br_taken_cnt = br_q;
  assign mon.signature    = sig_q;
  assign mon.halt_pc      = hpc_q;
endmodule

// File: tb/tb_riscv_run_monitor.sv
// tb_riscv_run_monitor: directed checks of halt, self-loop, timeout, counters and signature
module tb_riscv_run_monitor;
  logic clk = 1'b0;
  logic start = 1'b0;
  int checks = 0;
  int failures = 0;
  riscv_run_monitor_if #(.XLEN(32), .CNT_W(32)) mon ();
  riscv_run_monitor #(.XLEN(32), .CNT_W(32), .MAX_CYCLES(300), .HALT_REPEAT(4)) dut (
    .clk(clk), .start(start), .mon(mon)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic e, input logic [31:0] p, input logic [31:0] ins,
                     input logic rw, input logic [31:0] wb, input logic mw,
                     input logic [31:0] ma, input logic [31:0] md, input logic b, input logic z);
    mon.en = e; mon.pc = p; mon.instr = ins; mon.reg_write = rw; mon.wb_data = wb;
    mon.mem_write = mw; mon.mem_addr = ma; mon.mem_wdata = md; mon.branch = b; mon.zero = z;
    @(posedge clk); #1;
  endtask
  task automatic nop(input logic [31:0] p);
    cyc(1'b1, p, 32'h13, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask
  task automatic restart();
    mon.clr = 1'b1;
    cyc(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    mon.clr = 1'b0;
    cyc(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask
  initial begin
    mon.clr = 1'b0;
    mon.en = 1'b0; mon.pc = 0; mon.instr = 0; mon.reg_write = 0; mon.wb_data = 0;
    mon.mem_write = 0; mon.mem_addr = 0; mon.mem_wdata = 0; mon.branch = 0; mon.zero = 0;
    #12;
    chk("rst_state", mon.state, 0);
    chk("rst_done", mon.done, 0);
    start = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("idle_to_run", mon.state, 1);
    chk("idle_no_sample", mon.cycle_cnt, 0);
    for (int i = 0; i < 299; i++) nop(32'(4 * i));
    chk("to_299_run", mon.state, 1);
    nop(32'd1196);
    chk("to_state", mon.state, 3);
    chk("to_done", mon.done, 1);
    chk("to_timeout", mon.timeout, 1);
    chk("to_cycles", mon.cycle_cnt, 300);
    chk("to_instrs", mon.instr_cnt, 300);
    chk("to_sig", mon.signature, 0);
    chk("to_hpc", mon.halt_pc, 0);
    nop(32'd1200);
    chk("to_sticky", mon.cycle_cnt, 300);
    restart();
    chk("clr_cycles", mon.cycle_cnt, 0);
    for (int i = 0; i < 4; i++) nop(32'(4 * i));
    chk("eb_not_yet", mon.done, 0);
    cyc(1'b1, 32'h14, 32'h00100073, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("eb_state", mon.state, 2);
    chk("eb_cycles", mon.cycle_cnt, 5);
    chk("eb_hpc", mon.halt_pc, 32'h14);
    chk("eb_timeout", mon.timeout, 0);
    mon.clr = 1'b1;
    cyc(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    mon.clr = 1'b0;
    chk("clr_halt_state", mon.state, 0);
    chk("clr_halt_hpc", mon.halt_pc, 0);
    chk("clr_halt_cyc", mon.cycle_cnt, 0);
    cyc(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) nop(32'(4 * (i - 1)));
    for (int i = 10; i <= 13; i++) nop(32'h40);
    chk("loop_13", mon.done, 0);
    nop(32'h40);
    chk("loop_14_state", mon.state, 2);
    chk("loop_hpc", mon.halt_pc, 32'h40);
    chk("loop_cycles", mon.cycle_cnt, 14);
    restart();
    cyc(1'b1, 0, 32'h293, 1'b1, 32'h1, 1'b0, 0, 0, 1'b0, 1'b0);
    cyc(1'b1, 4, 32'h293, 1'b1, 32'h2, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("sig_1_2", mon.signature, 0);
    restart();
    cyc(1'b1, 0, 32'h293, 1'b1, 32'h1, 1'b0, 0, 0, 1'b0, 1'b0);
    cyc(1'b1, 4, 32'h293, 1'b1, 32'h3, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("sig_1_3", mon.signature, 1);
    cyc(1'b1, 8, 32'h13, 1'b1, 32'hFFFF, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("sig_x0", mon.signature, 1);
    cyc(1'b1, 12, 32'h23, 1'b0, 0, 1'b1, 32'h10, 32'h3, 1'b0, 1'b0);
    chk("sig_store", mon.signature, 32'h11);
    restart();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(4 * i), 32'h13, 1'b0, 0, 1'b1, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h100, 32'h13, 1'b0, 0, 1'b1, 0, 0, 1'b1, 1'b1);
    cyc(1'b1, 12, 32'h13, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b1);
    cyc(1'b1, 16, 32'h13, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b1);
    cyc(1'b1, 20, 32'h13, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("cnt_store", mon.store_cnt, 3);
    chk("cnt_br", mon.br_taken_cnt, 2);
    chk("cnt_cycles", mon.cycle_cnt, 6);
    chk("cnt_instrs", mon.instr_cnt, 6);
    restart();
    for (int i = 0; i < 299; i++) nop(32'(4 * i));
    cyc(1'b1, 32'h4AC, 32'h00000073, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("ec300_state", mon.state, 2);
    chk("ec300_timeout", mon.timeout, 0);
    chk("ec300_cycles", mon.cycle_cnt, 300);
    chk("ec300_hpc", mon.halt_pc, 32'h4AC);
    restart();
    for (int i = 0; i < 3; i++) nop(32'(4 * i));
    chk("pre_rst_cycles", mon.cycle_cnt, 3);
    #2 start = 1'b0;
    #1;
    chk("arst_state", mon.state, 0);
    chk("arst_cycles", mon.cycle_cnt, 0);
    chk("arst_instrs", mon.instr_cnt, 0);
    chk("arst_done", mon.done, 0);
    start = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
